// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SECOND = 1'b1
    } wb_state_t;

    localparam int          MULT_CYCLES = 4;
    localparam int          DIV_CYCLES  = 32;
    localparam int          MDU_CNT_W   = 6;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding mux: MEM result wins over WB, register 0 is never forwarded.
module fwd_select
    import mips_pipe_pkg::*;
(
    input  logic [4:0]  i_src,
    input  logic        i_use,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [31:0] i_mem_value,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_wr,
    input  logic [31:0] i_wb_value,
    output logic        o_fwd,
    output logic [31:0] o_value
);

    logic w_live;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_live    = i_use && (i_src != REG_ZERO);
    assign w_mem_hit = w_live && i_mem_wr && (i_mem_rd == i_src);
    assign w_wb_hit  = w_live && i_wb_wr  && (i_wb_rd  == i_src);

    always_comb begin
        o_fwd   = 1'b0;
        o_value = 32'd0;
        if (w_mem_hit) begin
            o_fwd   = 1'b1;
            o_value = i_mem_value;
        end else if (w_wb_hit) begin
            o_fwd   = 1'b1;
            o_value = i_wb_value;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage MIPS pipeline: operand forwarding, load-use and
// MDU-busy stalls, and a one-cycle freeze for instructions needing two WB writes.
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = mips_pipe_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = mips_pipe_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_mdu_op,
    input  logic        id_mdu_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_register_write,
    input  logic        ex_load,
    input  logic        ex_mdu_start,
    input  logic        ex_mdu_div,
    input  logic [4:0]  mem_rd,
    input  logic        mem_register_write,
    input  logic [31:0] mem_value,
    input  logic [4:0]  wb_rd,
    input  logic        wb_register_write,
    input  logic [31:0] wb_value,
    input  logic        wb_double,
    output logic        stall,
    output logic        double_write_back_stall,
    output logic        wb_second,
    output logic        forwarding_rs,
    output logic        forwarding_rt,
    output logic [31:0] fu_value_rs,
    output logic [31:0] fu_value_rt,
    output logic        mdu_busy
);
    import mips_pipe_pkg::*;

    fwd_select u_fwd_rs (
        .i_src       (id_rs),
        .i_use       (id_use_rs),
        .i_mem_rd    (mem_rd),
        .i_mem_wr    (mem_register_write),
        .i_mem_value (mem_value),
        .i_wb_rd     (wb_rd),
        .i_wb_wr     (wb_register_write),
        .i_wb_value  (wb_value),
        .o_fwd       (forwarding_rs),
        .o_value     (fu_value_rs)
    );

    fwd_select u_fwd_rt (
        .i_src       (id_rt),
        .i_use       (id_use_rt),
        .i_mem_rd    (mem_rd),
        .i_mem_wr    (mem_register_write),
        .i_mem_value (mem_value),
        .i_wb_rd     (wb_rd),
        .i_wb_wr     (wb_register_write),
        .i_wb_value  (wb_value),
        .o_fwd       (forwarding_rt),
        .o_value     (fu_value_rt)
    );

    logic w_load_use;
    assign w_load_use = ex_load && ex_register_write && (ex_rd != REG_ZERO) &&
                        ((id_use_rs && (ex_rd == id_rs)) ||
                         (id_use_rt && (ex_rd == id_rt)));

    // MDU countdown: a new start always reloads, even while busy.
    logic [MDU_CNT_W-1:0] r_count;
    logic [MDU_CNT_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (ex_mdu_start)
            w_count_next = ex_mdu_div ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MULT_CYCLES);
        else if (r_count != '0)
            w_count_next = r_count - MDU_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else
            r_count <= w_count_next;
    end

    assign mdu_busy = (r_count != '0);
    assign stall    = w_load_use || (mdu_busy && (id_mdu_op || id_mdu_read));

    wb_state_t r_state;
    wb_state_t w_state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    // Freeze is masked during reset so the reset-state outputs stay quiet.
    always_comb begin
        w_state_next            = r_state;
        double_write_back_stall = 1'b0;
        wb_second               = 1'b0;
        case (r_state)
            RUN: begin
                if (wb_double && wb_register_write) begin
                    double_write_back_stall = !reset;
                    w_state_next            = SECOND;
                end
            end
            SECOND: begin
                wb_second    = 1'b1;
                w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt, id_mdu_op, id_mdu_read;
    logic [4:0]  ex_rd;
    logic        ex_register_write, ex_load, ex_mdu_start, ex_mdu_div;
    logic [4:0]  mem_rd;
    logic        mem_register_write;
    logic [31:0] mem_value;
    logic [4:0]  wb_rd;
    logic        wb_register_write;
    logic [31:0] wb_value;
    logic        wb_double;
    logic        stall, double_write_back_stall, wb_second;
    logic        forwarding_rs, forwarding_rt;
    logic [31:0] fu_value_rs, fu_value_rt;
    logic        mdu_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_cyc = 0;   // first cycle count at which the MDU result is available

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu_op(id_mdu_op), .id_mdu_read(id_mdu_read),
        .ex_rd(ex_rd), .ex_register_write(ex_register_write), .ex_load(ex_load),
        .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
        .mem_rd(mem_rd), .mem_register_write(mem_register_write), .mem_value(mem_value),
        .wb_rd(wb_rd), .wb_register_write(wb_register_write), .wb_value(wb_value),
        .wb_double(wb_double),
        .stall(stall), .double_write_back_stall(double_write_back_stall),
        .wb_second(wb_second), .forwarding_rs(forwarding_rs), .forwarding_rt(forwarding_rt),
        .fu_value_rs(fu_value_rs), .fu_value_rt(fu_value_rt), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: forwarded value for one operand, or -1 marker via the found flag.
    function automatic void ref_fwd(input logic use_r, input logic [4:0] r,
                                    output logic found, output logic [31:0] val);
        found = 1'b0;
        val   = 32'd0;
        if (use_r && r != 0) begin
            if (mem_register_write && mem_rd == r) begin
                found = 1'b1; val = mem_value;
            end else if (wb_register_write && wb_rd == r) begin
                found = 1'b1; val = wb_value;
            end
        end
    endfunction

    function automatic logic ref_load_use();
        return ex_load && ex_register_write && ex_rd != 0 &&
               ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_mdu_op = 0; id_mdu_read = 0;
        ex_rd = 0; ex_register_write = 0; ex_load = 0; ex_mdu_start = 0; ex_mdu_div = 0;
        mem_rd = 0; mem_register_write = 0; mem_value = 0;
        wb_rd = 0; wb_register_write = 0; wb_value = 0; wb_double = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        wb_double = 1; wb_register_write = 1;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (mdu_busy !== 1'b0 || wb_second !== 1'b0 || double_write_back_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b second=%b dwbs=%b required 0,0,0",
                     mdu_busy, wb_second, double_write_back_stall);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        ready_cyc = cyc;
    endtask

    task automatic test_forwarding();
        logic f_rs, f_rt;
        logic [31:0] v_rs, v_rt;
        @(negedge clk);
        clear_inputs();
        id_rs = 5; id_use_rs = 1;
        mem_rd = 5; mem_register_write = 1; mem_value = 32'hAAAA0000;
        wb_rd = 5; wb_register_write = 1; wb_value = 32'h0000_5555;
        #1;
        checks++;
        if (forwarding_rs !== 1'b1 || fu_value_rs !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL fwd_mem_priority fwd=%b val=%h required 1 aaaa0000", forwarding_rs, fu_value_rs);
        end
        @(negedge clk);
        clear_inputs();
        id_rt = 0; id_use_rt = 1; mem_rd = 0; mem_register_write = 1; mem_value = 32'h1234;
        ex_load = 1; ex_register_write = 1; ex_rd = 0;
        #1;
        checks++;
        if (forwarding_rt !== 1'b0 || stall !== 1'b0 || fu_value_rt !== 32'd0) begin
            errors++;
            $display("FAIL reg_zero fwd_rt=%b stall=%b val=%h required 0 0 0", forwarding_rt, stall, fu_value_rt);
        end
        // Random patterns over a small register range to force collisions.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            clear_inputs();
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_rd = 5'($urandom_range(0, 3)); ex_register_write = 1'($urandom); ex_load = 1'($urandom);
            mem_rd = 5'($urandom_range(0, 3)); mem_register_write = 1'($urandom); mem_value = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_register_write = 1'($urandom); wb_value = $urandom;
            #1;
            ref_fwd(id_use_rs, id_rs, f_rs, v_rs);
            ref_fwd(id_use_rt, id_rt, f_rt, v_rt);
            checks++;
            if (forwarding_rs !== f_rs || fu_value_rs !== v_rs ||
                forwarding_rt !== f_rt || fu_value_rt !== v_rt) begin
                errors++;
                $display("FAIL fwd_rand[%0d] rs=%b/%h rt=%b/%h required rs=%b/%h rt=%b/%h", i,
                         forwarding_rs, fu_value_rs, forwarding_rt, fu_value_rt, f_rs, v_rs, f_rt, v_rt);
            end
            checks++;
            if (stall !== ref_load_use()) begin
                errors++;
                $display("FAIL stall_rand[%0d] stall=%b required %b", i, stall, ref_load_use());
            end
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        ex_load = 1; ex_register_write = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_hit stall=%b required 1", stall);
        end
        @(negedge clk);
        ex_load = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_clear stall=%b required 0", stall);
        end
    endtask

    task automatic test_mdu_div();
        @(negedge clk);
        clear_inputs();
        ex_mdu_start = 1; ex_mdu_div = 1;
        @(negedge clk);
        ex_mdu_start = 0; ex_mdu_div = 0; id_mdu_read = 1;
        for (int i = 0; i < 33; i++) begin
            #1;
            checks++;
            if (mdu_busy !== (i < 32) || stall !== (i < 32)) begin
                errors++;
                $display("FAIL div_busy[%0d] busy=%b stall=%b required %b", i, mdu_busy, stall, (i < 32));
            end
            @(negedge clk);
        end
        ready_cyc = cyc;
    endtask

    task automatic test_mdu_random();
        logic exp_busy;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            clear_inputs();
            id_mdu_op = 1'($urandom); id_mdu_read = 1'($urandom);
            ex_mdu_start = ($urandom_range(0, 9) == 0);
            ex_mdu_div = 1'($urandom);
            #1;
            exp_busy = (cyc < ready_cyc);
            checks++;
            if (mdu_busy !== exp_busy || stall !== (exp_busy && (id_mdu_op || id_mdu_read))) begin
                errors++;
                $display("FAIL mdu_rand[%0d] busy=%b stall=%b required busy=%b stall=%b", i,
                         mdu_busy, stall, exp_busy, exp_busy && (id_mdu_op || id_mdu_read));
            end
            if (ex_mdu_start)
                ready_cyc = cyc + 1 + (ex_mdu_div ? 32 : 4);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_double_wb();
        @(negedge clk);
        clear_inputs();
        wb_double = 1; wb_register_write = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (double_write_back_stall !== (i == 0) || wb_second !== (i == 1)) begin
                errors++;
                $display("FAIL dbl_wb[%0d] dwbs=%b second=%b required %b %b", i,
                         double_write_back_stall, wb_second, (i == 0), (i == 1));
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_inputs();
        ex_mdu_start = 1; ex_mdu_div = 1;
        wb_double = 1; wb_register_write = 1;
        @(negedge clk);
        clear_inputs();
        wb_double = 1; wb_register_write = 1;
        #1;
        checks++;
        if (wb_second !== 1'b1 || mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort second=%b busy=%b required 1 1", wb_second, mdu_busy);
        end
        #1 reset = 1'b1;
        ex_load = 1; ex_register_write = 1; ex_rd = 9; id_rs = 9; id_use_rs = 1;
        mem_rd = 9; mem_register_write = 1; mem_value = 32'hCAFE_F00D;
        #1;
        checks++;
        if (wb_second !== 1'b0 || mdu_busy !== 1'b0 || double_write_back_stall !== 1'b0) begin
            errors++;
            $display("FAIL async_abort second=%b busy=%b dwbs=%b required 0 0 0",
                     wb_second, mdu_busy, double_write_back_stall);
        end
        checks++;
        if (stall !== 1'b1 || forwarding_rs !== 1'b1 || fu_value_rs !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL comb_in_reset stall=%b fwd=%b val=%h required 1 1 cafef00d",
                     stall, forwarding_rs, fu_value_rs);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        ready_cyc = cyc;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu_div();
        test_mdu_random();
        test_double_wb();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
